// File: rtl/mpa_header_decode_if.sv
// MPEG audio header decoder port bundle.
// Buffer/controller side is master, decoder side is slave.
interface mpa_header_decode_if;
  logic        Header_Start_I;
  logic        Header_Done_O;
  logic        Header_Valid_O;
  logic        Sync_Timeout_O;
  logic        Bitstream_Byte_Allign_I;
  logic [15:0] Bitstream_Data_I;
  logic [1:0]  Shift_En_O;
  logic [1:0]  Layer_O;
  logic [1:0]  Sample_Freq_O;
  logic [8:0]  Bitrate_Kbps_O;
  logic        Channels_O;
  logic [2:0]  Table_O;
  logic [4:0]  Sblimit_O;
  logic [4:0]  Bound_O;
  logic        CRC_Present_O;
  logic [15:0] CRC_Word_O;

  modport slave (
    input  Header_Start_I,
    input  Bitstream_Byte_Allign_I,
    input  Bitstream_Data_I,
    output Header_Done_O,
    output Header_Valid_O,
    output Sync_Timeout_O,
    output Shift_En_O,
    output Layer_O,
    output Sample_Freq_O,
    output Bitrate_Kbps_O,
    output Channels_O,
    output Table_O,
    output Sblimit_O,
    output Bound_O,
    output CRC_Present_O,
    output CRC_Word_O
  );

  modport master (
    output Header_Start_I,
    output Bitstream_Byte_Allign_I,
    output Bitstream_Data_I,
    input  Header_Done_O,
    input  Header_Valid_O,
    input  Sync_Timeout_O,
    input  Shift_En_O,
    input  Layer_O,
    input  Sample_Freq_O,
    input  Bitrate_Kbps_O,
    input  Channels_O,
    input  Table_O,
    input  Sblimit_O,
    input  Bound_O,
    input  CRC_Present_O,
    input  CRC_Word_O
  );
endinterface

// File: rtl/mpa_header_decode.sv
// MPEG-1/LSF audio frame header decoder: sync search,
// header/CRC capture, bitrate and Layer II table decode.
module mpa_header_decode #(
  parameter int         SHIFT_LATENCY = 1,
  parameter int         SYNC_TIMEOUT  = 4096,
  parameter logic [2:0] LAYER_MASK    = 3'b010,
  parameter bit         ALLOW_LSF     = 1'b1
) (
  input logic clock,
  input logic resetn,
  mpa_header_decode_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, SYNC, WAIT, INFO, CRC, CHECK
  } state_t;

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);
  localparam int WW = $clog2(SHIFT_LATENCY + 2);
  localparam logic [CW-1:0] CLIM = CW'(SYNC_TIMEOUT);
  localparam logic [WW-1:0] WLAST = WW'(SHIFT_LATENCY - 1);

  localparam logic [8:0] T_M1L2 [16] = '{
    9'd0, 9'd32, 9'd48, 9'd56, 9'd64, 9'd80,
    9'd96, 9'd112, 9'd128, 9'd160, 9'd192,
    9'd224, 9'd256, 9'd320, 9'd384, 9'd0};
  localparam logic [8:0] T_M1L3 [16] = '{
    9'd0, 9'd32, 9'd40, 9'd48, 9'd56, 9'd64,
    9'd80, 9'd96, 9'd112, 9'd128, 9'd160,
    9'd192, 9'd224, 9'd256, 9'd320, 9'd0};
  localparam logic [8:0] T_LSF1 [16] = '{
    9'd0, 9'd32, 9'd48, 9'd56, 9'd64, 9'd80,
    9'd96, 9'd112, 9'd128, 9'd144, 9'd160,
    9'd176, 9'd192, 9'd224, 9'd256, 9'd0};
  localparam logic [8:0] T_LSF2 [16] = '{
    9'd0, 9'd8, 9'd16, 9'd24, 9'd32, 9'd40,
    9'd48, 9'd56, 9'd64, 9'd80, 9'd96,
    9'd112, 9'd128, 9'd144, 9'd160, 9'd0};

  state_t state, nstate, ret_q, ret_d, tgt;
  logic jump, tmo_set, match;
  logic [WW-1:0] wcnt, wcnt_d;
  logic [CW-1:0] scnt, scnt_d;
  logic [1:0] shift;

  logic ver_q, prot_q;
  logic [1:0] layer_q, fs_q, mode_q, mext_q;
  logic [3:0] bri_q;

  logic lsf, chan, ok;
  logic [8:0] kbps, bhalf;
  logic [2:0] tsel;
  logic [4:0] sbl, jbnd, bnd;

  assign match = bus.Bitstream_Byte_Allign_I
               & (bus.Bitstream_Data_I[15:4] == 12'hFFF);
  assign bus.Header_Done_O = (state == IDLE);
  assign bus.Shift_En_O = shift;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ret_q <= IDLE;
      wcnt  <= '0;
      scnt  <= '0;
    end else begin
      state <= nstate;
      ret_q <= ret_d;
      wcnt  <= wcnt_d;
      scnt  <= scnt_d;
    end
  end

  always_comb begin
    nstate  = state;
    ret_d   = ret_q;
    wcnt_d  = wcnt;
    scnt_d  = scnt;
    shift   = 2'b00;
    tmo_set = 1'b0;
    jump    = 1'b0;
    tgt     = IDLE;
    unique case (state)
      IDLE: if (bus.Header_Start_I) begin
        nstate = SYNC;
        scnt_d = '0;
      end
      SYNC: if (match) begin
        shift = 2'b10;
        jump  = 1'b1;
        tgt   = INFO;
      end else if (scnt == CLIM) begin
        tmo_set = 1'b1;
        nstate  = IDLE;
      end else begin
        shift  = 2'b01;
        scnt_d = scnt + 1'b1;
        jump   = 1'b1;
        tgt    = SYNC;
      end
      WAIT: if (wcnt == WLAST) nstate = ret_q;
            else wcnt_d = wcnt + 1'b1;
      INFO: begin
        shift = 2'b10;
        jump  = 1'b1;
        tgt   = prot_q ? CHECK : CRC;
      end
      CRC: begin
        shift = 2'b10;
        jump  = 1'b1;
        tgt   = CHECK;
      end
      CHECK: nstate = IDLE;
      default: nstate = IDLE;
    endcase
    // every shift parks in WAIT until the buffer refills
    if (jump) begin
      if (SHIFT_LATENCY == 0) nstate = tgt;
      else begin
        nstate = WAIT;
        ret_d  = tgt;
        wcnt_d = '0;
      end
    end
  end

  always_comb begin
    lsf  = ~ver_q;
    kbps = '0;
    if (bri_q != 4'd0 && bri_q != 4'd15) begin
      unique case (1'b1)
        (layer_q == 2'b11) && !lsf: kbps = {bri_q, 5'b0};
        (layer_q == 2'b10) && !lsf: kbps = T_M1L2[bri_q];
        (layer_q == 2'b01) && !lsf: kbps = T_M1L3[bri_q];
        (layer_q == 2'b11) && lsf:  kbps = T_LSF1[bri_q];
        (layer_q == 2'b10 || layer_q == 2'b01) && lsf:
          kbps = T_LSF2[bri_q];
        default: kbps = '0;
      endcase
    end
    chan  = (mode_q != 2'b11);
    bhalf = chan ? {1'b0, kbps[8:1]} : kbps;
    if (layer_q != 2'b10) tsel = 3'd0;
    else if (lsf) tsel = 3'd4;
    else if (fs_q == 2'b01 && bhalf >= 9'd56) tsel = 3'd0;
    else if (bhalf >= 9'd56 && bhalf <= 9'd80) tsel = 3'd0;
    else if (fs_q != 2'b01 && bhalf >= 9'd96) tsel = 3'd1;
    else if (fs_q != 2'b10 && bhalf <= 9'd48) tsel = 3'd2;
    else tsel = 3'd3;
    unique case (tsel)
      3'd0: sbl = 5'd27;
      3'd1: sbl = 5'd30;
      3'd2: sbl = 5'd8;
      3'd3: sbl = 5'd12;
      default: sbl = 5'd30;
    endcase
    jbnd = {({1'b0, mext_q} + 3'd1), 2'b00};
    bnd  = sbl;
    if (mode_q == 2'b01 && jbnd < sbl) bnd = jbnd;
    ok = ((layer_q == 2'b11) & LAYER_MASK[0])
       | ((layer_q == 2'b10) & LAYER_MASK[1])
       | ((layer_q == 2'b01) & LAYER_MASK[2]);
    if (bri_q == 4'd0 || bri_q == 4'd15) ok = 1'b0;
    if (fs_q == 2'b11) ok = 1'b0;
    if (lsf && !ALLOW_LSF) ok = 1'b0;
    if (!lsf && layer_q == 2'b10) begin
      if (!chan && kbps > 9'd192) ok = 1'b0;
      if (chan && (kbps == 9'd32 || kbps == 9'd48
          || kbps == 9'd56 || kbps == 9'd80)) ok = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      {ver_q, prot_q, layer_q} <= '0;
      {bri_q, fs_q, mode_q, mext_q} <= '0;
      bus.Header_Valid_O <= 1'b0;
      bus.Sync_Timeout_O <= 1'b0;
      bus.Layer_O        <= '0;
      bus.Sample_Freq_O  <= '0;
      bus.Bitrate_Kbps_O <= '0;
      bus.Channels_O     <= 1'b0;
      bus.Table_O        <= '0;
      bus.Sblimit_O      <= '0;
      bus.Bound_O        <= '0;
      bus.CRC_Present_O  <= 1'b0;
      bus.CRC_Word_O     <= '0;
    end else begin
      if (state == IDLE && bus.Header_Start_I) begin
        bus.Sync_Timeout_O <= 1'b0;
        bus.Header_Valid_O <= 1'b0;
      end
      if (tmo_set) bus.Sync_Timeout_O <= 1'b1;
      if (state == SYNC && match)
        {ver_q, layer_q, prot_q} <= bus.Bitstream_Data_I[3:0];
      if (state == INFO) begin
        bri_q  <= bus.Bitstream_Data_I[15:12];
        fs_q   <= bus.Bitstream_Data_I[11:10];
        mode_q <= bus.Bitstream_Data_I[7:6];
        mext_q <= bus.Bitstream_Data_I[5:4];
      end
      if (state == CRC) bus.CRC_Word_O <= bus.Bitstream_Data_I;
      if (state == CHECK) begin
        bus.Header_Valid_O <= ok;
        bus.Layer_O        <= layer_q;
        bus.Sample_Freq_O  <= fs_q;
        bus.Bitrate_Kbps_O <= kbps;
        bus.Channels_O     <= chan;
        bus.Table_O        <= tsel;
        bus.Sblimit_O      <= sbl;
        bus.Bound_O        <= bnd;
        bus.CRC_Present_O  <= ~prot_q;
      end
    end
  end
endmodule
